// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, fixed latency.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;      // negate product / quotient
    logic              rneg_q, rneg_d;    // negate remainder
    logic              div0_q, div0_d;
    logic [WIDTH-1:0]  mag_q, mag_d;      // multiplicand or divisor magnitude
    logic [AW-1:0]     acc_q, acc_d;      // product accumulator or {remainder, quotient}
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    logic              sgn_op;
    logic [WIDTH-1:0]  rs_mag;
    logic [WIDTH-1:0]  rt_mag;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_up;
    logic [WIDTH:0]    div_diff;
    logic [AW-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;

    // Datapath helpers: operand magnitudes, one iteration step, and sign fix-up
    always_comb begin
        sgn_op   = ~op[0];
        rs_mag   = (sgn_op && rs_data[WIDTH-1]) ? (~rs_data + WIDTH'(1)) : rs_data;
        rt_mag   = (sgn_op && rt_data[WIDTH-1]) ? (~rt_data + WIDTH'(1)) : rt_data;
        mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : {WIDTH{1'b0}})};
        div_up   = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_up - {1'b0, mag_q};
        prod_fix = neg_q ? (~acc_q + AW'(1)) : acc_q;
        quo      = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem      = rneg_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
    end

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[1];
                    neg_d    = sgn_op && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    rneg_d   = sgn_op && rs_data[WIDTH-1];
                    div0_d   = op[1] && (rt_data == '0);
                    mag_d    = op[1] ? rt_mag : rs_mag;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    if (hi_we) hi_d = hi_wdata;
                    if (lo_we) lo_d = lo_wdata;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = {(div_diff[WIDTH] ? div_up[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo;
                    hi_d = rem;
                end else begin
                    hi_d = prod_fix[AW-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic with the divide-by-zero rule layered on top
    task automatic model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo);
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (m_op)
            2'b00: begin p = 64'(sa * sb); e_hi = p[63:32]; e_lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
            2'b10: begin
                if (b == 32'd0) begin e_hi = a; e_lo = 32'hFFFF_FFFF; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    e_lo = 32'(sq); e_hi = 32'(sr);
                end
            end
            default: begin
                if (b == 32'd0) begin e_hi = a; e_lo = 32'hFFFF_FFFF; end
                else begin e_lo = a / b; e_hi = a % b; end
            end
        endcase
    endtask

    task automatic launch(input logic [1:0] l_op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = l_op; rs_data = a; rt_data = b;
        step();
        start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        step();
        while (!done && edges < 60) begin
            step();
            edges++;
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] r_op,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] e_hi, e_lo;
        int          edges;
        model(r_op, a, b, e_hi, e_lo);
        launch(r_op, a, b);
        wait_done(edges);
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(e_hi));
        check({tag, "_lo"}, 64'(lo), 64'(e_lo));
    endtask

    initial begin
        logic [31:0] e_hi, e_lo, a, b;
        logic [1:0]  r_op;
        int          edges;
        logic        saw_busy, saw_done;

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
        step(); step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        step();

        // mthi + mtlo together, then mthi alone
        hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h1234_5678; lo_wdata = 32'h9ABC_DEF0;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mt_both_hi", 64'(hi), 64'h1234_5678);
        check("mt_both_lo", 64'(lo), 64'h9ABC_DEF0);
        hi_we = 1'b1; hi_wdata = 32'hCAFE_F00D;
        step();
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'hCAFE_F00D);
        check("mthi_lo_kept", 64'(lo), 64'h9ABC_DEF0);

        // Directed corner cases
        run_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        check("done_busy_low", 64'(busy), 64'd0);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        run_check("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7);
        run_check("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_m7d2_lo_const", 64'(lo), 64'hFFFF_FFFD);
        run_check("divu_7d2", 2'b11, 32'd7, 32'd2);
        run_check("divu_d0", 2'b11, 32'd100, 32'd0);
        run_check("div_d0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
        run_check("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        run_check("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);

        // start and mthi during RUN are ignored; first result intact, nothing queued
        model(2'b00, 32'h0001_2345, 32'hFFFF_0F0F, e_hi, e_lo);
        launch(2'b00, 32'h0001_2345, 32'hFFFF_0F0F);
        edges = 0;
        do begin
            start = (edges == 4);
            if (edges == 4) begin op = 2'b11; rs_data = 32'd9; rt_data = 32'd4; end
            hi_we = (edges == 9);
            hi_wdata = 32'hDEAD_BEEF;
            step();
            edges++;
        end while (!done && edges < 60);
        start = 1'b0; hi_we = 1'b0;
        check("ign_latency", 64'(edges), 64'd33);
        check("ign_hi", 64'(hi), 64'(e_hi));
        check("ign_lo", 64'(lo), 64'(e_lo));
        saw_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy) saw_busy = 1'b1;
        end
        check("ign_no_queue", 64'(saw_busy), 64'd0);

        // start in the done cycle is accepted
        run_check("b2b_first", 2'b11, 32'd1000, 32'd7);
        run_check("b2b_second", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // reset mid-RUN aborts with no result
        launch(2'b01, 32'hFFFF_FFFF, 32'h1234_5678);
        for (int i = 0; i < 12; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        // Random operations, with occasional zero/small/extreme operands
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_check($sformatf("rand%0d_op%0d", i, r_op), r_op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
